// File: rtl/edge_pe_fv_req_master.sv
// ---------------------------------------------------------------------------
// edge_pe_fv_req_master
// Requester-side endpoint facing one Big FV bank port. It takes one read or
// write command at a time from an Edge PE. A read issues a single request
// beat and captures the tagged response stream into a fall-through FIFO. A
// write streams sos..eos data beats straight through to the bank.
//
// Ports
//   clk, reset                 clock / async active-low reset
//   cmd_*                      command handshake (rd_wr, node id, length)
//   wr_data_*                  write-beat handshake from the PE
//   available                  bank can take a request this cycle
//   req_pkt_*                  request bundle to the bank (combinational)
//   rd_in_*                    tagged response stream from the bank
//   rsp_*                      FIFO head towards the PE datapath
//   busy, err                  FSM not idle / sticky protocol error
// ---------------------------------------------------------------------------
module edge_pe_fv_req_master #(
    parameter int unsigned FV_BW     = 16,
    parameter int unsigned NODE_W    = 8,
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned MY_TAG    = 0,
    parameter int unsigned MAX_BEATS = 8,
    localparam int unsigned LEN_W    = $clog2(MAX_BEATS) + 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd_wr,
    input  logic [NODE_W-1:0] cmd_node_id,
    input  logic [LEN_W-1:0]  cmd_len,

    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    input  logic [FV_BW-1:0]  wr_data,

    input  logic              available,
    output logic              req_pkt_valid,
    output logic              req_pkt_rd_wr,
    output logic              req_pkt_wr_sos,
    output logic              req_pkt_wr_eos,
    output logic [TAG_W-1:0]  req_pkt_PE_tag,
    output logic [NODE_W-1:0] req_pkt_Node_id,
    output logic [FV_BW-1:0]  req_pkt_data,

    input  logic              rd_in_valid,
    input  logic              rd_in_sos,
    input  logic              rd_in_eos,
    input  logic [TAG_W-1:0]  rd_in_PE_tag,
    input  logic [FV_BW-1:0]  rd_in_FV_data,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FV_BW-1:0]  rsp_data,
    output logic              rsp_sos,
    output logic              rsp_eos,

    output logic              busy,
    output logic              err
);

    localparam int unsigned PTR_W = $clog2(MAX_BEATS);
    localparam int unsigned ENT_W = FV_BW + 2;
    localparam logic [TAG_W-1:0] MY_TAG_T = TAG_W'(MY_TAG);
    localparam logic [LEN_W-1:0] FIFO_DEPTH = LEN_W'(MAX_BEATS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RD_REQ    = 2'd1;
    localparam logic [1:0] S_RD_WAIT   = 2'd2;
    localparam logic [1:0] S_WR_STREAM = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [NODE_W-1:0] node_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [ENT_W-1:0]  mem [MAX_BEATS];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0]  fill_q;

    logic cmd_accept_c;
    logic fifo_empty_c;
    logic rd_fire_c;
    logic wr_fire_c;
    logic last_wr_c;
    logic rsp_hit_c;
    logic in_range_c;
    logic push_c;
    logic pop_c;

    // Handshake and datapath qualifiers
    always_comb begin
        cmd_accept_c = cmd_valid && (state_q == S_IDLE);
        fifo_empty_c = (fill_q == '0);
        // Bank has no backpressure: only request once the FIFO can hold a full FV
        rd_fire_c    = (state_q == S_RD_REQ) && available && fifo_empty_c;
        wr_fire_c    = (state_q == S_WR_STREAM) && wr_data_valid && available;
        last_wr_c    = (cnt_q == (len_q - LEN_W'(1)));
        rsp_hit_c    = (state_q == S_RD_WAIT) && rd_in_valid && (rd_in_PE_tag == MY_TAG_T);
        in_range_c   = (cnt_q < len_q);
        push_c       = rsp_hit_c && in_range_c && (fill_q != FIFO_DEPTH);
        pop_c        = !fifo_empty_c && rsp_ready;
    end

    // State, beat counter and sticky error register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, beat counting and error detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept_c) begin
                    cnt_d = '0;
                    if (cmd_len != '0) begin
                        state_d = cmd_rd_wr ? S_WR_STREAM : S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (rd_fire_c) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (rsp_hit_c) begin
                    if (in_range_c) begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if ((cnt_q == '0) && !rd_in_sos) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        // Overrun beat: dropped, keep waiting for eos
                        err_d = 1'b1;
                    end
                    if (rd_in_eos) begin
                        state_d = S_IDLE;
                        if (!in_range_c || ((cnt_q + LEN_W'(1)) != len_q)) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_WR_STREAM: begin
                if (wr_fire_c) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_wr_c) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command field latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            node_q <= '0;
            len_q  <= '0;
        end else if (cmd_accept_c) begin
            node_q <= cmd_node_id;
            len_q  <= cmd_len;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fill_q <= fill_q + LEN_W'(1);
                2'b01:   fill_q <= fill_q - LEN_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Response FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= {rd_in_FV_data, rd_in_sos, rd_in_eos};
        end
    end

    // Output decode
    always_comb begin
        cmd_ready       = (state_q == S_IDLE);
        busy            = (state_q != S_IDLE);
        err             = err_q;
        wr_data_ready   = (state_q == S_WR_STREAM) && available;
        req_pkt_valid   = rd_fire_c || wr_fire_c;
        req_pkt_rd_wr   = (state_q == S_WR_STREAM);
        req_pkt_wr_sos  = wr_fire_c && (cnt_q == '0);
        req_pkt_wr_eos  = wr_fire_c && last_wr_c;
        req_pkt_PE_tag  = MY_TAG_T;
        req_pkt_Node_id = node_q;
        req_pkt_data    = wr_fire_c ? wr_data : '0;
        rsp_valid       = !fifo_empty_c;
        // Head is masked while empty so stale storage never leaks out
        {rsp_data, rsp_sos, rsp_eos} = fifo_empty_c ? ENT_W'(0) : mem[rd_ptr_q];
    end

endmodule

// File: tb/tb_edge_pe_fv_req_master.sv
// Directed self-checking bench for edge_pe_fv_req_master.
module tb_edge_pe_fv_req_master;

    localparam int unsigned FV_BW = 16;
    localparam int unsigned NODE_W = 8;
    localparam int unsigned TAG_W = 2;
    localparam int unsigned MY_TAG = 0;
    localparam int unsigned MAX_BEATS = 8;
    localparam int unsigned LEN_W = 4;
    localparam logic [TAG_W-1:0] ME = 2'd0;
    localparam logic [TAG_W-1:0] OTHER = 2'd1;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid, cmd_ready, cmd_rd_wr;
    logic [NODE_W-1:0] cmd_node_id;
    logic [LEN_W-1:0] cmd_len;
    logic wr_data_valid, wr_data_ready;
    logic [FV_BW-1:0] wr_data;
    logic available;
    logic req_pkt_valid, req_pkt_rd_wr, req_pkt_wr_sos, req_pkt_wr_eos;
    logic [TAG_W-1:0] req_pkt_PE_tag;
    logic [NODE_W-1:0] req_pkt_Node_id;
    logic [FV_BW-1:0] req_pkt_data;
    logic rd_in_valid, rd_in_sos, rd_in_eos;
    logic [TAG_W-1:0] rd_in_PE_tag;
    logic [FV_BW-1:0] rd_in_FV_data;
    logic rsp_valid, rsp_ready, rsp_sos, rsp_eos;
    logic [FV_BW-1:0] rsp_data;
    logic busy, err;

    int checks = 0;
    int errors = 0;

    // Request-beat log, sampled mid-low-phase when all inputs are settled
    int req_n = 0;
    int wr_n = 0;
    logic [FV_BW-1:0] wr_d [64];
    logic wr_s [64];
    logic wr_e [64];

    edge_pe_fv_req_master #(
        .FV_BW(FV_BW), .NODE_W(NODE_W), .TAG_W(TAG_W),
        .MY_TAG(MY_TAG), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_node_id(cmd_node_id), .cmd_len(cmd_len),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
        .available(available),
        .req_pkt_valid(req_pkt_valid), .req_pkt_rd_wr(req_pkt_rd_wr),
        .req_pkt_wr_sos(req_pkt_wr_sos), .req_pkt_wr_eos(req_pkt_wr_eos),
        .req_pkt_PE_tag(req_pkt_PE_tag), .req_pkt_Node_id(req_pkt_Node_id),
        .req_pkt_data(req_pkt_data),
        .rd_in_valid(rd_in_valid), .rd_in_sos(rd_in_sos), .rd_in_eos(rd_in_eos),
        .rd_in_PE_tag(rd_in_PE_tag), .rd_in_FV_data(rd_in_FV_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_sos(rsp_sos), .rsp_eos(rsp_eos),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (reset && req_pkt_valid) begin
            req_n = req_n + 1;
            if (req_pkt_rd_wr && wr_n < 64) begin
                wr_d[wr_n] = req_pkt_data;
                wr_s[wr_n] = req_pkt_wr_sos;
                wr_e[wr_n] = req_pkt_wr_eos;
                wr_n = wr_n + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus drivers; all start and end just after a falling edge
    task automatic apply_reset();
        reset = 1'b0;
        cmd_valid = 0; cmd_rd_wr = 0; cmd_node_id = '0; cmd_len = '0;
        wr_data_valid = 0; wr_data = '0; available = 1'b1;
        rd_in_valid = 0; rd_in_sos = 0; rd_in_eos = 0; rd_in_PE_tag = '0; rd_in_FV_data = '0;
        rsp_ready = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic issue_cmd(input logic rw, input logic [NODE_W-1:0] node, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1; cmd_rd_wr = rw; cmd_node_id = node; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [TAG_W-1:0] tag, input logic s, input logic e, input logic [FV_BW-1:0] d);
        rd_in_valid = 1'b1; rd_in_PE_tag = tag; rd_in_sos = s; rd_in_eos = e; rd_in_FV_data = d;
        @(negedge clk);
        rd_in_valid = 1'b0; rd_in_sos = 0; rd_in_eos = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        available = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cmd_ready=%b busy=%b err=%b exp 1,0,0", cmd_ready, busy, err);
        end
        checks++;
        if (req_pkt_valid !== 1'b0 || wr_data_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: req=%b wrr=%b rsp=%b exp 0,0,0", req_pkt_valid, wr_data_ready, rsp_valid);
        end
        checks++;
        if (req_pkt_PE_tag !== ME || req_pkt_Node_id !== 8'h00 || req_pkt_data !== 16'h0 || rsp_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: tag=%h node=%h data=%h rsp=%h exp 0", req_pkt_PE_tag, req_pkt_Node_id, req_pkt_data, rsp_data);
        end
        apply_reset();
    endtask

    task automatic test_read_normal();
        int base;
        base = req_n;
        issue_cmd(1'b0, 8'd5, 4'd4);
        #1;
        checks++;
        if (req_pkt_valid !== 1'b1 || req_pkt_rd_wr !== 1'b0 || req_pkt_Node_id !== 8'd5 ||
            req_pkt_PE_tag !== ME || req_pkt_wr_sos !== 1'b0 || req_pkt_wr_eos !== 1'b0) begin
            errors++;
            $display("FAIL rd_req: v=%b rw=%b node=%0d tag=%0d sos=%b eos=%b exp 1,0,5,0,0,0",
                     req_pkt_valid, req_pkt_rd_wr, req_pkt_Node_id, req_pkt_PE_tag, req_pkt_wr_sos, req_pkt_wr_eos);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_beat(ME, i == 0, i == 3, 16'(16'hA000 + i));
        end
        #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || req_n - base != 1) begin
            errors++;
            $display("FAIL rd_done: busy=%b err=%b pulses=%0d exp 0,0,1", busy, err, req_n - base);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'(16'hA000 + i) || rsp_sos !== (i == 0) || rsp_eos !== (i == 3)) begin
                errors++;
                $display("FAIL rd_rsp%0d: v=%b data=%h sos=%b eos=%b", i, rsp_valid, rsp_data, rsp_sos, rsp_eos);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_drained: rsp_valid=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_foreign_tag();
        issue_cmd(1'b0, 8'd3, 4'd4);
        @(negedge clk);
        send_beat(ME, 1, 0, 16'hB000);
        send_beat(OTHER, 1, 0, 16'hDEAD);
        send_beat(ME, 0, 0, 16'hB001);
        send_beat(OTHER, 0, 1, 16'hBEEF);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL foreign_eos_ignored: busy=%b exp 1", busy);
        end
        send_beat(ME, 0, 0, 16'hB002);
        send_beat(ME, 0, 1, 16'hB003);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'(16'hB000 + i)) begin
                errors++;
                $display("FAIL foreign_rsp%0d: v=%b data=%h exp 1,%h", i, rsp_valid, rsp_data, 16'(16'hB000 + i));
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL foreign_occupancy: rsp_valid=%b err=%b busy=%b exp 0,0,0", rsp_valid, err, busy);
        end
    endtask

    task automatic test_write_stall();
        int base;
        base = wr_n;
        issue_cmd(1'b1, 8'd7, 4'd3);
        wr_data_valid = 1'b1;
        wr_data = 16'h000A;
        #1;
        checks++;
        if (wr_data_ready !== 1'b1 || req_pkt_valid !== 1'b1 || req_pkt_Node_id !== 8'd7) begin
            errors++;
            $display("FAIL wr_first: wrr=%b v=%b node=%0d exp 1,1,7", wr_data_ready, req_pkt_valid, req_pkt_Node_id);
        end
        @(negedge clk);
        wr_data = 16'h000B;
        available = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (wr_data_ready !== 1'b0 || req_pkt_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_stall%0d: wrr=%b v=%b exp 0,0", i, wr_data_ready, req_pkt_valid);
            end
            @(negedge clk);
        end
        available = 1'b1;
        @(negedge clk);
        wr_data = 16'h000C;
        @(negedge clk);
        wr_data_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wr_n - base != 3) begin
            errors++;
            $display("FAIL wr_done: busy=%b beats=%0d exp 0,3", busy, wr_n - base);
        end
        else begin
            checks++;
            if (wr_d[base] !== 16'hA || wr_d[base+1] !== 16'hB || wr_d[base+2] !== 16'hC ||
                {wr_s[base], wr_e[base], wr_s[base+1], wr_e[base+1], wr_s[base+2], wr_e[base+2]} !== 6'b10_00_01) begin
                errors++;
                $display("FAIL wr_beats: data=%h,%h,%h soseos=%b%b %b%b %b%b exp a,b,c 10 00 01",
                         wr_d[base], wr_d[base+1], wr_d[base+2], wr_s[base], wr_e[base],
                         wr_s[base+1], wr_e[base+1], wr_s[base+2], wr_e[base+2]);
            end
        end
    endtask

    task automatic test_len_zero();
        int base;
        base = req_n;
        issue_cmd(1'b0, 8'd2, 4'd0);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_idle: cmd_ready=%b busy=%b exp 1,0", cmd_ready, busy);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_n != base) begin
            errors++;
            $display("FAIL len0_nopkt: pulses=%0d exp 0", req_n - base);
        end
    endtask

    task automatic test_write_len1();
        issue_cmd(1'b1, 8'd8, 4'd1);
        wr_data_valid = 1'b1;
        wr_data = 16'h5A5A;
        #1;
        checks++;
        if (req_pkt_valid !== 1'b1 || req_pkt_rd_wr !== 1'b1 || req_pkt_wr_sos !== 1'b1 ||
            req_pkt_wr_eos !== 1'b1 || req_pkt_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL wr_len1: v=%b rw=%b sos=%b eos=%b data=%h exp 1,1,1,1,5a5a",
                     req_pkt_valid, req_pkt_rd_wr, req_pkt_wr_sos, req_pkt_wr_eos, req_pkt_data);
        end
        @(negedge clk);
        wr_data_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_len1_done: busy=%b cmd_ready=%b exp 0,1", busy, cmd_ready);
        end
    endtask

    task automatic test_stale_fifo();
        issue_cmd(1'b0, 8'd1, 4'd2);
        @(negedge clk);
        send_beat(ME, 1, 0, 16'h0011);
        send_beat(ME, 0, 1, 16'h0022);
        issue_cmd(1'b0, 8'd4, 4'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_pkt_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stale_hold%0d: v=%b busy=%b exp 0,1", i, req_pkt_valid, busy);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_data !== 16'h0011) begin
            errors++;
            $display("FAIL stale_pop0: data=%h exp 0011", rsp_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_data !== 16'h0022 || req_pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_pop1: data=%h v=%b exp 0022,0", rsp_data, req_pkt_valid);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_pkt_valid !== 1'b1 || req_pkt_Node_id !== 8'd4) begin
            errors++;
            $display("FAIL stale_release: v=%b node=%0d exp 1,4", req_pkt_valid, req_pkt_Node_id);
        end
        @(negedge clk);
        send_beat(ME, 1, 1, 16'h0033);
        #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || rsp_data !== 16'h0033 || rsp_sos !== 1'b1 || rsp_eos !== 1'b1) begin
            errors++;
            $display("FAIL stale_rsp: busy=%b err=%b data=%h sos=%b eos=%b exp 0,0,0033,1,1",
                     busy, err, rsp_data, rsp_sos, rsp_eos);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        issue_cmd(1'b0, 8'd6, 4'd4);
        @(negedge clk);
        send_beat(ME, 1, 0, 16'hC000);
        send_beat(ME, 0, 0, 16'hC001);
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0 ||
            req_pkt_valid !== 1'b0 || req_pkt_Node_id !== 8'h00 || rsp_data !== 16'h0) begin
            errors++;
            $display("FAIL midrst_values: rdy=%b busy=%b rspv=%b err=%b v=%b node=%h rsp=%h",
                     cmd_ready, busy, rsp_valid, err, req_pkt_valid, req_pkt_Node_id, rsp_data);
        end
        @(negedge clk);
        reset = 1'b1;
        send_beat(ME, 0, 0, 16'hC002);
        send_beat(ME, 0, 1, 16'hC003);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_late: rsp_valid=%b busy=%b err=%b exp 0,0,0", rsp_valid, busy, err);
        end
    endtask

    task automatic test_len_mismatch();
        issue_cmd(1'b0, 8'd9, 4'd2);
        @(negedge clk);
        send_beat(ME, 1, 0, 16'h0001);
        send_beat(ME, 0, 0, 16'h0002);
        send_beat(ME, 0, 1, 16'h0003);
        #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL mism_done: busy=%b err=%b exp 0,1", busy, err);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_data !== 16'h0001 || rsp_sos !== 1'b1) begin
            errors++;
            $display("FAIL mism_rsp0: data=%h sos=%b exp 0001,1", rsp_data, rsp_sos);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_data !== 16'h0002 || rsp_eos !== 1'b0) begin
            errors++;
            $display("FAIL mism_rsp1: data=%h eos=%b exp 0002,0", rsp_data, rsp_eos);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL mism_sticky: rsp_valid=%b err=%b exp 0,1", rsp_valid, err);
        end
    endtask

    initial begin
        test_reset();
        test_read_normal();
        test_foreign_tag();
        test_write_stall();
        test_len_zero();
        test_write_len1();
        test_stale_fifo();
        test_reset_mid_read();
        test_len_mismatch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
